// File: rtl/adc_sample_framer.sv
// adc_sample_framer
// Turns the stream of 24-bit SPI words from the ADC into per-channel samples.
// Each DRDY frame starts with a status word (word_sof) whose upper byte must
// match STATUS_ID. It is followed by NUM_CH channel words, which are
// sign-extended to 32 bits and queued in an output FIFO with a ready/valid
// handshake.
//
// Ports
//   system_clock     rising-edge clock
//   reset_n          asynchronous active-low reset
//   word_valid       one-cycle strobe, word_data holds a completed SPI word
//   word_sof         with word_valid: the word is the frame status word
//   word_data[23:0]  received word, MSB first
//   out_valid        FIFO head holds a sample
//   out_ready        consumer accepts the head when out_valid is also high
//   out_channel[1:0] channel index of the head sample
//   out_sample[31:0] head sample, sign-extended
//   out_last         head is the last channel of its frame
//   frame_err_count  saturating count of rejected or truncated frames
//   overflow_count   saturating count of samples dropped on a full FIFO
//   status_word      lower 16 bits of the last accepted status word
module adc_sample_framer #(
  parameter int         NUM_CH     = 4,
  parameter logic [7:0] STATUS_ID  = 8'h22,
  parameter int         FIFO_DEPTH = 8
) (
  input  logic        system_clock,
  input  logic        reset_n,
  input  logic        word_valid,
  input  logic        word_sof,
  input  logic [23:0] word_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  out_channel,
  output logic [31:0] out_sample,
  output logic        out_last,
  output logic [7:0]  frame_err_count,
  output logic [7:0]  overflow_count,
  output logic [15:0] status_word
);

  localparam int             PW       = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int             CW       = PW + 1;
  localparam int             IW       = 35;
  localparam logic [1:0]     LAST_CH  = 2'(NUM_CH - 1);
  localparam logic [CW-1:0]  BODY_MAX = CW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CHAN    = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  function automatic logic [31:0] sign_ext(input logic [23:0] d);
    sign_ext = {{8{d[23]}}, d};
  endfunction

  function automatic logic [7:0] sat_add(input logic [7:0] cnt, input logic [1:0] inc);
    logic [8:0] sum;
    sum = {1'b0, cnt} + {7'b0000000, inc};
    if (sum[8]) sat_add = 8'hFF;
    else        sat_add = sum[7:0];
  endfunction

  state_t           state_r, state_nxt_s;
  logic [1:0]       chan_cnt_r;
  logic             sof_s, id_ok_s;
  logic [1:0]       err_inc_s;
  logic             load_status_s, cnt_clr_s, cnt_inc_s, wr_req_s;

  logic             wr_pend_r;
  logic [IW-1:0]    wr_item_r;

  logic [IW-1:0]    head_r;
  logic             out_valid_r;
  logic [IW-1:0]    body_mem_r [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]    body_cnt_r;
  logic             pop_s, full_s, push_s, drop_s, body_empty_s;
  logic             head_new_s, head_body_s, body_push_s;

  logic [7:0]       frame_err_r, overflow_r;
  logic [15:0]      status_r;

  assign sof_s   = word_valid & word_sof;
  assign id_ok_s = (word_data[23:16] == STATUS_ID);

  // FSM state register
  always_ff @(posedge system_clock or negedge reset_n) begin
    if (!reset_n) state_r <= ST_IDLE;
    else          state_r <= state_nxt_s;
  end

  // FSM next state: a status word restarts framing from any state
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE, ST_DISCARD: begin
        if (sof_s) state_nxt_s = id_ok_s ? ST_CHAN : ST_DISCARD;
        else       state_nxt_s = state_r;
      end
      ST_CHAN: begin
        if (sof_s)                                  state_nxt_s = id_ok_s ? ST_CHAN : ST_DISCARD;
        else if (word_valid && chan_cnt_r == LAST_CH) state_nxt_s = ST_IDLE;
        else                                        state_nxt_s = ST_CHAN;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM outputs; a bad-ID status word truncating a frame costs two errors
  always_comb begin
    err_inc_s     = 2'd0;
    load_status_s = 1'b0;
    cnt_clr_s     = 1'b0;
    cnt_inc_s     = 1'b0;
    wr_req_s      = 1'b0;
    case (state_r)
      ST_IDLE, ST_DISCARD: begin
        if (sof_s && id_ok_s) begin
          load_status_s = 1'b1;
          cnt_clr_s     = 1'b1;
        end else if (sof_s) begin
          err_inc_s = 2'd1;
        end else begin
          err_inc_s = 2'd0;
        end
      end
      ST_CHAN: begin
        if (sof_s && id_ok_s) begin
          err_inc_s     = 2'd1;
          load_status_s = 1'b1;
          cnt_clr_s     = 1'b1;
        end else if (sof_s) begin
          err_inc_s = 2'd2;
        end else if (word_valid) begin
          wr_req_s  = 1'b1;
          cnt_inc_s = 1'b1;
        end else begin
          wr_req_s = 1'b0;
        end
      end
      default: begin
        err_inc_s = 2'd0;
      end
    endcase
  end

  // Channel counter, status capture and the one-cycle write staging register
  always_ff @(posedge system_clock or negedge reset_n) begin
    if (!reset_n) begin
      chan_cnt_r <= 2'd0;
      status_r   <= 16'h0000;
      wr_pend_r  <= 1'b0;
      wr_item_r  <= {IW{1'b0}};
    end else begin
      if (cnt_clr_s)      chan_cnt_r <= 2'd0;
      else if (cnt_inc_s) chan_cnt_r <= chan_cnt_r + 2'd1;
      if (load_status_s)  status_r   <= word_data[15:0];
      wr_pend_r <= wr_req_s;
      if (wr_req_s) wr_item_r <= {chan_cnt_r, sign_ext(word_data), (chan_cnt_r == LAST_CH)};
    end
  end

  // FIFO = head register (drives out_*) + body ring; total capacity FIFO_DEPTH.
  // A pop in the same cycle frees the slot the pending write needs.
  assign pop_s        = out_valid_r & out_ready;
  assign body_empty_s = (body_cnt_r == {CW{1'b0}});
  assign full_s       = out_valid_r & (body_cnt_r == BODY_MAX);
  assign push_s       = wr_pend_r & (~full_s | pop_s);
  assign drop_s       = wr_pend_r & full_s & ~pop_s;
  assign head_new_s   = push_s & (~out_valid_r | (pop_s & body_empty_s));
  assign head_body_s  = pop_s & ~body_empty_s;
  assign body_push_s  = push_s & ~head_new_s;

  // Head register and body bookkeeping
  always_ff @(posedge system_clock or negedge reset_n) begin
    if (!reset_n) begin
      head_r      <= {IW{1'b0}};
      out_valid_r <= 1'b0;
      wr_ptr_r    <= {PW{1'b0}};
      rd_ptr_r    <= {PW{1'b0}};
      body_cnt_r  <= {CW{1'b0}};
    end else begin
      if (head_new_s) begin
        head_r      <= wr_item_r;
        out_valid_r <= 1'b1;
      end else if (head_body_s) begin
        head_r      <= body_mem_r[rd_ptr_r];
        out_valid_r <= 1'b1;
      end else if (pop_s) begin
        out_valid_r <= 1'b0;
      end
      if (body_push_s) wr_ptr_r <= wr_ptr_r + PW'(1'b1);
      if (head_body_s) rd_ptr_r <= rd_ptr_r + PW'(1'b1);
      case ({body_push_s, head_body_s})
        2'b10:   body_cnt_r <= body_cnt_r + CW'(1'b1);
        2'b01:   body_cnt_r <= body_cnt_r - CW'(1'b1);
        default: body_cnt_r <= body_cnt_r;
      endcase
    end
  end

  // Body storage; contents are don't-care until written
  always_ff @(posedge system_clock) begin
    if (body_push_s) body_mem_r[wr_ptr_r] <= wr_item_r;
  end

  // Saturating error and overflow counters
  always_ff @(posedge system_clock or negedge reset_n) begin
    if (!reset_n) begin
      frame_err_r <= 8'h00;
      overflow_r  <= 8'h00;
    end else begin
      frame_err_r <= sat_add(frame_err_r, err_inc_s);
      overflow_r  <= sat_add(overflow_r, {1'b0, drop_s});
    end
  end

  assign out_valid       = out_valid_r;
  assign out_channel     = head_r[34:33];
  assign out_sample      = head_r[32:1];
  assign out_last        = head_r[0];
  assign frame_err_count = frame_err_r;
  assign overflow_count  = overflow_r;
  assign status_word     = status_r;

endmodule

// File: tb/tb_adc_sample_framer.sv
// Self-checking bench for adc_sample_framer: a queue-based model of the
// framer plus FIFO is compared with the DUT every cycle; directed scenarios
// pin the model with literal values, then random traffic runs.
module tb_adc_sample_framer;

  localparam int         NUM_CH = 4;
  localparam int         DEPTH  = 8;
  localparam logic [7:0] ID     = 8'h22;

  logic        system_clock, reset_n;
  logic        word_valid, word_sof, out_ready;
  logic [23:0] word_data;
  logic        out_valid, out_last;
  logic [1:0]  out_channel;
  logic [31:0] out_sample;
  logic [7:0]  frame_err_count, overflow_count;
  logic [15:0] status_word;

  int tests = 0;
  int fails = 0;

  adc_sample_framer #(.NUM_CH(NUM_CH), .STATUS_ID(ID), .FIFO_DEPTH(DEPTH)) dut (
    .system_clock(system_clock), .reset_n(reset_n),
    .word_valid(word_valid), .word_sof(word_sof), .word_data(word_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_channel(out_channel),
    .out_sample(out_sample), .out_last(out_last),
    .frame_err_count(frame_err_count), .overflow_count(overflow_count),
    .status_word(status_word)
  );

  initial system_clock = 1'b0;
  always #10 system_clock = ~system_clock;

  // Model state: m_ch is the next expected channel, -1 when outside a frame.
  int          m_ch, m_err, m_ovf;
  logic [15:0] m_status;
  logic        m_pend;
  logic [34:0] m_item;
  logic [34:0] mq[$];
  logic [34:0] got[$];

  function automatic int sat(input int x);
    return (x < 255) ? x + 1 : 255;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: consumer pop, then last cycle's sample lands, then the new word.
  initial begin
    forever begin
      @(posedge system_clock or negedge reset_n);
      if (!reset_n) begin
        m_ch = -1; m_err = 0; m_ovf = 0; m_status = 16'h0000; m_pend = 1'b0;
        mq.delete();
      end else begin
        if (mq.size() > 0 && out_ready) begin
          got.push_back(mq[0]);
          void'(mq.pop_front());
        end
        if (m_pend) begin
          if (mq.size() < DEPTH) mq.push_back(m_item);
          else                   m_ovf = sat(m_ovf);
        end
        m_pend = 1'b0;
        if (word_valid) begin
          if (word_sof) begin
            if (m_ch >= 0) m_err = sat(m_err);
            if (word_data[23:16] == ID) begin
              m_ch = 0;
              m_status = word_data[15:0];
            end else begin
              m_err = sat(m_err);
              m_ch = -1;
            end
          end else if (m_ch >= 0) begin
            m_pend = 1'b1;
            m_item = {2'(m_ch), 32'($signed(word_data)), (m_ch == NUM_CH - 1)};
            m_ch++;
            if (m_ch == NUM_CH) m_ch = -1;
          end
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model
  initial begin
    forever begin
      @(negedge system_clock);
      chk("out_valid", out_valid, mq.size() > 0);
      if (mq.size() > 0) chk("head", {out_channel, out_sample, out_last}, mq[0]);
      chk("frame_err_count", frame_err_count, m_err);
      chk("overflow_count", overflow_count, m_ovf);
      chk("status_word", status_word, m_status);
    end
  end

  task automatic send(input logic sof, input logic [23:0] d);
    word_valid = 1'b1; word_sof = sof; word_data = d;
    @(negedge system_clock);
    word_valid = 1'b0; word_sof = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge system_clock);
  endtask

  task automatic frame(input logic [23:0] st, input int base);
    send(1'b1, st);
    for (int c = 0; c < NUM_CH; c++) send(1'b0, 24'(base + c));
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 64 && (out_valid || mq.size() > 0); i++) @(negedge system_clock);
    chk("drain_timeout", out_valid, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0; word_valid = 1'b0; word_sof = 1'b0; word_data = 24'h0; out_ready = 1'b0;
    idle(3);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_sample", {out_channel, out_sample, out_last}, 35'h0);
    chk("rst_counts", {frame_err_count, overflow_count, status_word}, 32'h0);
    reset_n = 1'b1;
    idle(1);

    // Basic frame with sign extension
    out_ready = 1'b1; got.delete();
    send(1'b1, 24'h220500); send(1'b0, 24'h000001); send(1'b0, 24'hFFFFFF);
    send(1'b0, 24'h7FFFFF); send(1'b0, 24'h800000);
    idle(4);
    chk("f0_count", got.size(), 4);
    if (got.size() == 4) begin
      chk("f0_ch0", got[0], {2'd0, 32'h00000001, 1'b0});
      chk("f0_ch1", got[1], {2'd1, 32'hFFFFFFFF, 1'b0});
      chk("f0_ch2", got[2], {2'd2, 32'h007FFFFF, 1'b0});
      chk("f0_ch3", got[3], {2'd3, 32'hFF800000, 1'b1});
    end
    chk("f0_status", status_word, 16'h0500);

    // Wrong status ID: frame discarded, next frame fine
    got.delete();
    frame(24'h330000, 24'h000100);
    idle(4);
    chk("badid_nowrite", got.size(), 0);
    chk("badid_err", frame_err_count, 8'd1);
    frame(24'h221234, 24'h000200);
    idle(4);
    chk("badid_next", got.size(), 4);
    chk("badid_status", status_word, 16'h1234);

    // Truncated frame
    got.delete();
    send(1'b1, 24'h22AAAA); send(1'b0, 24'h00000A); send(1'b0, 24'h00000B);
    frame(24'h220001, 24'h000010);
    idle(4);
    chk("trunc_err", frame_err_count, 8'd2);
    chk("trunc_count", got.size(), 6);
    if (got.size() == 6) begin
      chk("trunc_0", got[0], {2'd0, 32'h0000000A, 1'b0});
      chk("trunc_1", got[1], {2'd1, 32'h0000000B, 1'b0});
      chk("trunc_2", got[2], {2'd0, 32'h00000010, 1'b0});
      chk("trunc_5", got[5], {2'd3, 32'h00000013, 1'b1});
    end

    // Overflow with the consumer stalled
    out_ready = 1'b0;
    for (int f = 1; f <= 3; f++) frame(24'h220000, f * 16);
    idle(3);
    chk("ovf_count", overflow_count, 8'd4);
    chk("ovf_occupancy", mq.size(), DEPTH);
    chk("ovf_valid", out_valid, 1'b1);
    got.delete();
    drain();
    chk("ovf_drained", got.size(), 8);
    if (got.size() == 8) begin
      for (int i = 0; i < 8; i++)
        chk("ovf_order", got[i], {2'(i % 4), 32'(16 * (1 + i / 4) + i % 4), (i % 4) == 3});
    end

    // Full FIFO: write and read in the same cycle
    out_ready = 1'b0;
    frame(24'h220000, 24'h000040); frame(24'h220000, 24'h000050);
    idle(3);
    send(1'b1, 24'h220000); send(1'b0, 24'h123456);
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;
    idle(1);
    chk("full_rw_ovf", overflow_count, 8'd4);
    chk("full_rw_occ", mq.size(), DEPTH);
    got.delete();
    drain();
    chk("full_rw_cnt", got.size(), 8);
    if (got.size() > 0) chk("full_rw_last", got[got.size() - 1], {2'd0, 32'h00123456, 1'b0});

    // Reset in the middle of a frame
    out_ready = 1'b0;
    send(1'b1, 24'h220000); send(1'b0, 24'h000001); send(1'b0, 24'h000002); send(1'b0, 24'h000003);
    idle(1);
    #3 reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_head", {out_channel, out_sample, out_last}, 35'h0);
    chk("mid_rst_counts", {frame_err_count, overflow_count, status_word}, 32'h0);
    @(negedge system_clock);
    reset_n = 1'b1;
    send(1'b0, 24'h000004);
    idle(3);
    chk("post_rst_ignored", out_valid, 1'b0);
    out_ready = 1'b1; got.delete();
    frame(24'h220777, 24'h000060);
    idle(4);
    chk("post_rst_frame", got.size(), 4);

    // Counter saturation
    repeat (260) send(1'b1, 24'h110000);
    chk("err_sat", frame_err_count, 8'hFF);
    out_ready = 1'b0;
    repeat (70) frame(24'h220000, 24'($urandom));
    idle(3);
    chk("ovf_sat", overflow_count, 8'hFF);
    drain();

    // Random traffic from a clean reset
    reset_n = 1'b0;
    idle(1);
    reset_n = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      word_valid = ($urandom_range(0, 2) != 0);
      word_sof   = ($urandom_range(0, 5) == 0);
      word_data  = 24'($urandom);
      if (word_sof && $urandom_range(0, 3) != 0) word_data[23:16] = ID;
      out_ready  = (i < 1500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      @(negedge system_clock);
    end
    word_valid = 1'b0; word_sof = 1'b0;
    idle(2);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/adc_sample_framer.md
ADC_SAMPLE_FRAMER -- requirements
Module: adc_sample_framer

Interface
REQ-001 Parameter NUM_CH, default 4, number of ADC channel words per frame (legal 1..4).
REQ-002 Parameter STATUS_ID, default 8'h22, required upper byte of the frame status word.
REQ-003 Parameter FIFO_DEPTH, default 8, output FIFO entries (power of two, 2..16).
REQ-004 system_clock  in  1  50 MHz clock; all logic rising-edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 word_valid  in  1  one-cycle strobe: word_data holds a completed 24-bit SPI word from SPI_Master.
REQ-007 word_sof  in  1  qualified by word_valid; marks the first word (status) of a DRDY frame.
REQ-008 word_data  in  24  received MISO word, MSB first as shifted in.
REQ-009 out_valid  out  1  FIFO head holds a sample.
REQ-010 out_ready  in  1  consumer accepts head when out_valid and out_ready are both high.
REQ-011 out_channel  out  2  channel index of head sample.
REQ-012 out_sample  out  32  head sample, 24-bit two's-complement sign-extended.
REQ-013 out_last  out  1  head is channel NUM_CH-1 of its frame.
REQ-014 frame_err_count  out  8  saturating count of rejected frames.
REQ-015 overflow_count  out  8  saturating count of samples dropped because the FIFO was full.
REQ-016 status_word  out  16  lower 16 bits of the last accepted status word.

Function
REQ-017 FSM states: IDLE, CHAN, DISCARD; one word processed per word_valid, no backpressure on the input side.
REQ-018 IDLE: word_valid with word_sof and word_data[23:16]==STATUS_ID -> load status_word, clear channel counter, go CHAN.
REQ-019 IDLE: word_valid with word_sof and wrong ID -> frame_err_count+1, go DISCARD; word_valid without word_sof -> ignored, stay IDLE.
REQ-020 CHAN: word_valid without word_sof -> write {counter, sign-extended word, counter==NUM_CH-1} into the FIFO one cycle after the strobe; counter+1; after channel NUM_CH-1 go IDLE.
REQ-021 CHAN: word_valid with word_sof (frame truncated) -> frame_err_count+1, then that word is handled exactly as in IDLE in the same cycle.
REQ-022 DISCARD: words without word_sof are dropped; word_sof handled as in IDLE.
REQ-023 Sign extension: out_sample[31:24] = word_data[23] replicated.
REQ-024 FIFO write when full -> sample dropped, overflow_count+1, FSM progress unaffected; partial frames in the FIFO are not retracted.
REQ-025 Simultaneous write and read on a full FIFO: the read frees an entry and the write succeeds (no overflow).
REQ-026 Simultaneous write and read on an empty FIFO: write stored; out_valid rises the following cycle (no fall-through).
REQ-027 out_* are driven directly from the FIFO head register; out_valid deasserts only on handshake or reset; head contents stable while out_valid && !out_ready.
REQ-028 Counters saturate at 8'hFF, never wrap.
REQ-029 Latency: word_valid on cycle N (CHAN, FIFO empty) -> out_valid high on cycle N+2.

Reset
REQ-030 reset_n low asynchronously forces: FSM IDLE, channel counter 0, FIFO empty, out_valid 0, out_channel 0, out_sample 0, out_last 0, frame_err_count 0, overflow_count 0, status_word 0.
REQ-031 Reset asserted mid-frame discards the partial frame and FIFO contents; after release the first accepted word must be a valid word_sof.

Verification
REQ-032 Frame 0x220500, 0x000001, 0xFFFFFF, 0x7FFFFF, 0x800000 with out_ready=1 -> samples ch0..3 = 0x00000001, 0xFFFFFFFF, 0x007FFFFF, 0xFF800000; out_last only on ch3; status_word 0x0500.
REQ-033 Status word 0x330000 with sof followed by four words -> no FIFO writes, frame_err_count=1, next valid frame accepted normally.
REQ-034 Valid frame truncated after ch1 by a new valid sof frame -> frame_err_count=1, FIFO holds ch0, ch1 then ch0..ch3 of second frame in order.
REQ-035 out_ready=0, three 4-channel frames (12 samples), FIFO_DEPTH=8 -> 8 stored, overflow_count=4, draining yields frame1 ch0..3, frame2 ch0..3.
REQ-036 Full FIFO with out_ready=1 and word_valid in the same cycle -> no overflow, occupancy unchanged, order preserved.
REQ-037 reset_n pulsed low between ch2 and ch3 -> all outputs zero immediately; subsequent ch3 word without sof ignored; next valid frame produces four samples.
